mdu_div: RTL and testbench

//  Iterative RV32M divide unit (DIV/DIVU/REM/REMU) beside the single-cycle ALU.
//  The ALU answers within one cycle. This block accepts an operation through a start/busy/done

---
 rtl/mdu_div_pkg.sv | 43 ++++
 rtl/mdu_div_step.sv | 28 ++
 rtl/mdu_div.sv | 146 ++++++++++++++
 tb/tb_mdu_div.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_div_pkg.sv
// Shared definitions for the iterative RV32M divide unit.
//   XLEN / CNT_W  : operand width and iteration-counter width (log2 XLEN)
//   mdu_op_e      : divide operation codes shared with the instruction decoder
//   mdu_state_e   : divider FSM state codes, also exported on the debug port
//   helpers       : signedness/remainder decode and magnitude extraction
package mdu_div_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 5;

    localparam logic [XLEN-1:0] XLEN_MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        MDU_OP_DIV  = 2'b00,
        MDU_OP_DIVU = 2'b01,
        MDU_OP_REM  = 2'b10,
        MDU_OP_REMU = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE  = 2'b00,
        MDU_CALC  = 2'b01,
        MDU_FIXUP = 2'b10,
        MDU_DONE  = 2'b11
    } mdu_state_e;

    // op[0]=0 selects the signed variants (DIV, REM).
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    // op[1]=1 selects the remainder variants (REM, REMU).
    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

    // Magnitude of a possibly-signed operand. |0x8000_0000| wraps back to
    // 0x8000_0000, which is the correct unsigned magnitude.
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic is_signed);
        return (is_signed && v[XLEN-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step (purely combinational).
//   rem      : current partial remainder (XLEN+1 bits)
//   q_msb    : dividend/quotient bit shifted into the remainder this step
//   divisor  : unsigned divisor magnitude
//   rem_next : partial remainder after the trial subtract
//   q_bit    : quotient bit produced by this step
module mdu_div_step
    import mdu_div_pkg::*;
(
    input  logic [XLEN:0]   rem,
    input  logic            q_msb,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN:0]   rem_next,
    output logic            q_bit
);

    logic [XLEN+1:0] shifted;
    logic [XLEN+1:0] diff;

    always_comb begin
        shifted = {rem, q_msb};
        diff    = shifted - {2'b00, divisor};
        // No borrow out of the subtract means shifted >= divisor.
        q_bit    = ~diff[XLEN+1];
        rem_next = q_bit ? diff[XLEN:0] : shifted[XLEN:0];
    end

endmodule

// File: rtl/mdu_div.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU) for a single-cycle core.
//   clk, rst  : clock and synchronous active-high reset
//   start     : request, sampled only while the FSM is idle
//   op, A, B  : operation and operands, captured on the accepting edge
//   busy      : high from the cycle after acceptance through the done cycle
//   done      : one-cycle pulse, result valid
//   result    : quotient or remainder, held until the next accepted start
//   dbg_state : current FSM state for observation
//
// Handshake: a start seen high on a rising edge while idle is accepted and its
// operands captured; inputs need not be held afterwards. busy then stays high
// until and including the single done cycle; start is ignored while busy.
module mdu_div
    import mdu_div_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output mdu_state_e      dbg_state
);

    mdu_state_e      state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic            a_neg_q, a_neg_d;
    logic            b_neg_q, b_neg_d;
    logic [XLEN:0]   rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [XLEN:0]   step_rem;
    logic            step_bit;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;

    mdu_div_step u_step (
        .rem      (rem_q),
        .q_msb    (quo_q[XLEN-1]),
        .divisor  (div_q),
        .rem_next (step_rem),
        .q_bit    (step_bit)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        // Sign correction applied to the unsigned magnitudes: the quotient is
        // negative when operand signs differ, the remainder follows the dividend.
        quo_fix = (a_neg_q ^ b_neg_q) ? -quo_q : quo_q;
        rem_fix = a_neg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];

        case (state_q)
            MDU_IDLE: begin
                if (start) begin
                    op_d    = op;
                    a_neg_d = op_is_signed(op) & A[XLEN-1];
                    b_neg_d = op_is_signed(op) & B[XLEN-1];
                    if (B == '0) begin
                        result_d = op_is_rem(op) ? A : '1;
                        state_d  = MDU_DONE;
                    end else if (op_is_signed(op) && A == XLEN_MIN_NEG && B == '1) begin
                        result_d = op_is_rem(op) ? '0 : XLEN_MIN_NEG;
                        state_d  = MDU_DONE;
                    end else begin
                        // The quotient register starts out holding the dividend;
                        // its bits shift out into the remainder MSB first.
                        quo_d   = mag(A, op_is_signed(op));
                        div_d   = mag(B, op_is_signed(op));
                        rem_d   = '0;
                        cnt_d   = '0;
                        state_d = MDU_CALC;
                    end
                end
            end
            MDU_CALC: begin
                rem_d = step_rem;
                quo_d = {quo_q[XLEN-2:0], step_bit};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    state_d = MDU_FIXUP;
                end
            end
            MDU_FIXUP: begin
                result_d = op_is_rem(op_q) ? rem_fix : quo_fix;
                state_d  = MDU_DONE;
            end
            default: begin
                state_d = MDU_IDLE;
            end
        endcase

        busy_d = (state_d != MDU_IDLE);
        done_d = (state_d == MDU_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MDU_IDLE;
            op_q     <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mdu_div.sv
// Directed testbench for mdu_div: latency, signed/unsigned results, special
// cases, reset abort, back-to-back issue with held start, and a mixed sweep
// checked against a behavioural reference.
module tb_mdu_div;
    import mdu_div_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    mdu_state_e  dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, got no end expected summary");
        $fatal(1, "watchdog");
    end

    mdu_div dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .A         (a_in),
        .B         (b_in),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .dbg_state (dbg_state)
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (b == 32'h0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'h0 : 32'h8000_0000;
        case (o)
            2'b00:   return sa / sb;
            2'b01:   return a / b;
            2'b10:   return sa % sb;
            default: return a % b;
        endcase
    endfunction

    // ---------------- driver ----------------
    // Issues one op while the unit is idle. lat counts rising edges including
    // the accepting one until done is seen (0 on timeout). done_next is the
    // value of done one cycle after the pulse.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat,
                         output logic busy_after, output logic done_next);
        @(negedge clk);
        start = 1'b1; op = o; a_in = a; b_in = b;
        @(posedge clk); #1;
        start = 1'b0; a_in = $urandom; b_in = $urandom; op = 2'($urandom_range(0, 3));
        busy_after = busy;
        lat = 0;
        for (int i = 1; i <= 100; i++) begin
            if (done) begin
                lat = i;
                break;
            end
            @(posedge clk); #1;
        end
        res = result;
        @(posedge clk); #1;
        done_next = done;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = 2'b00; a_in = '0; b_in = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_cmp++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", result); end
        n_cmp++; if (dbg_state !== MDU_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, MDU_IDLE); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_unsigned();
        logic [31:0] res; int lat; logic bz; logic dn;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL divu_busy_before: got %b expected 0", busy); end
        issue(2'b01, 32'd100, 32'd7, res, lat, bz, dn);
        n_cmp++; if (bz !== 1'b1) begin n_fail++; $display("FAIL divu_busy_rise: got %b expected 1", bz); end
        n_cmp++; if (lat !== 34) begin n_fail++; $display("FAIL divu_latency: got %0d expected 34", lat); end
        n_cmp++; if (res !== 32'd14) begin n_fail++; $display("FAIL divu_result: got %0d expected 14", res); end
        n_cmp++; if (dn !== 1'b0) begin n_fail++; $display("FAIL divu_done_width: got %b expected 0", dn); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL divu_busy_after: got %b expected 0", busy); end
        issue(2'b11, 32'd100, 32'd7, res, lat, bz, dn);
        n_cmp++; if (res !== 32'd2) begin n_fail++; $display("FAIL remu_result: got %0d expected 2", res); end
        n_cmp++; if (lat !== 34) begin n_fail++; $display("FAIL remu_latency: got %0d expected 34", lat); end
    endtask

    task automatic test_signed();
        logic [31:0] res; int lat; logic bz; logic dn;
        issue(2'b00, 32'hFFFF_FFF9, 32'd2, res, lat, bz, dn);
        n_cmp++; if (res !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_neg_result: got %h expected fffffffd", res); end
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, res, lat, bz, dn);
        n_cmp++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rem_neg_result: got %h expected ffffffff", res); end
        issue(2'b00, 32'd7, 32'hFFFF_FFFE, res, lat, bz, dn);
        n_cmp++; if (res !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_negdivisor_result: got %h expected fffffffd", res); end
        issue(2'b10, 32'd7, 32'hFFFF_FFFE, res, lat, bz, dn);
        n_cmp++; if (res !== 32'd1) begin n_fail++; $display("FAIL rem_negdivisor_result: got %h expected 00000001", res); end
    endtask

    task automatic test_special();
        logic [31:0] res; int lat; logic bz; logic dn;
        issue(2'b00, 32'd5, 32'd0, res, lat, bz, dn);
        n_cmp++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div0_result: got %h expected ffffffff", res); end
        n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL div0_latency: got %0d expected 1", lat); end
        n_cmp++; if (bz !== 1'b1) begin n_fail++; $display("FAIL div0_busy: got %b expected 1", bz); end
        n_cmp++; if (dn !== 1'b0) begin n_fail++; $display("FAIL div0_done_width: got %b expected 0", dn); end
        issue(2'b11, 32'd5, 32'd0, res, lat, bz, dn);
        n_cmp++; if (res !== 32'd5) begin n_fail++; $display("FAIL remu0_result: got %h expected 00000005", res); end
        issue(2'b01, 32'd5, 32'd0, res, lat, bz, dn);
        n_cmp++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu0_result: got %h expected ffffffff", res); end
        issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, bz, dn);
        n_cmp++; if (res !== 32'h8000_0000) begin n_fail++; $display("FAIL ovf_div_result: got %h expected 80000000", res); end
        n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL ovf_div_latency: got %0d expected 1", lat); end
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, bz, dn);
        n_cmp++; if (res !== 32'h0) begin n_fail++; $display("FAIL ovf_rem_result: got %h expected 00000000", res); end
        // Unsigned ops with the same operands are ordinary divisions.
        issue(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, bz, dn);
        n_cmp++; if (res !== 32'h0) begin n_fail++; $display("FAIL divu_big_result: got %h expected 00000000", res); end
        n_cmp++; if (lat !== 34) begin n_fail++; $display("FAIL divu_big_latency: got %0d expected 34", lat); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] res; int lat; logic bz; logic dn; int seen;
        @(negedge clk);
        start = 1'b1; op = 2'b01; a_in = 32'd100; b_in = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);   // now in CALC with cnt==10
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b expected 0", done); end
        n_cmp++; if (result !== 32'h0) begin n_fail++; $display("FAIL abort_result: got %h expected 0", result); end
        @(negedge clk); rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses expected 0", seen); end
        issue(2'b01, 32'd9, 32'd3, res, lat, bz, dn);
        n_cmp++; if (res !== 32'd3) begin n_fail++; $display("FAIL abort_fresh_result: got %0d expected 3", res); end
        n_cmp++; if (lat !== 34) begin n_fail++; $display("FAIL abort_fresh_latency: got %0d expected 34", lat); end
    endtask

    function automatic logic [31:0] a_of(input int c);
        return 32'd1000 + 32'(c) * 32'd7;
    endfunction

    function automatic logic [31:0] b_of(input int c);
        return 32'd3 + 32'(c % 4);
    endfunction

    // start held high with operands changing every cycle: accepts happen at
    // cycles 0, 35, 70, each done follows its accept by 33 more edges.
    task automatic test_back_to_back();
        int n_done; int acc; logic [31:0] held; logic [31:0] expv;
        n_done = 0; held = '0;
        @(negedge clk);
        start = 1'b1; op = 2'b01; a_in = a_of(0); b_in = b_of(0);
        for (int cyc = 0; cyc < 200 && n_done < 3; cyc++) begin
            @(posedge clk); #1;
            if (done) begin
                acc  = n_done * 35;
                expv = a_of(acc) / b_of(acc);
                n_done++;
                n_cmp++; if (result !== expv) begin n_fail++; $display("FAIL b2b_result[%0d]: got %0d expected %0d", n_done, result, expv); end
                n_cmp++; if (cyc !== acc + 33) begin n_fail++; $display("FAIL b2b_spacing[%0d]: done at cycle %0d expected %0d", n_done, cyc, acc + 33); end
                held = result;
            end else if (n_done > 0) begin
                n_cmp++; if (result !== held) begin n_fail++; $display("FAIL b2b_stable: got %h expected %h at cycle %0d", result, held, cyc); end
            end
            @(negedge clk);
            a_in = a_of(cyc + 1); b_in = b_of(cyc + 1);
        end
        start = 1'b0;
        n_cmp++; if (n_done !== 3) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 3", n_done); end
        repeat (40) @(posedge clk);   // let any trailing op drain
    endtask

    task automatic test_sweep();
        logic [31:0] vals[8];
        logic [31:0] res; int lat; logic bz; logic dn;
        logic [1:0] o; logic [31:0] a; logic [31:0] b; logic [31:0] expv;
        vals = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd7, 32'hFFFF_FFF9, 32'd100};
        for (int i = 0; i < 20; i++) begin
            o = 2'($urandom_range(0, 3));
            a = ($urandom_range(0, 3) == 0) ? $urandom : vals[$urandom_range(0, 7)];
            b = ($urandom_range(0, 3) == 0) ? $urandom : vals[$urandom_range(0, 7)];
            exp_q.push_back(ref_model(o, a, b));
            issue(o, a, b, res, lat, bz, dn);
            expv = exp_q.pop_front();
            n_cmp++; if (res !== expv) begin n_fail++; $display("FAIL sweep_result op=%0d a=%h b=%h: got %h expected %h", o, a, b, res, expv); end
            n_cmp++; if (dn !== 1'b0) begin n_fail++; $display("FAIL sweep_done_width op=%0d: got %b expected 0", o, dn); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_special();
        test_reset_abort();
        test_back_to_back();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
